// File: rtl/rf_wb_scheduler_if.sv
// rf_wb_scheduler_if
// Bundles every non-clock/reset signal of the register-file write-port
// scheduler: pipeline writeback, load issue, cache return handshake,
// hazard-check request, register-file write port and the error flag.
//   master : core/cache side (drives requests, sees stall/hold/rf/err)
//   slave  : the scheduler itself
interface rf_wb_if;
  // pipeline writeback
  logic        p_we;
  logic        p_f;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  // load issue
  logic        iss_valid;
  logic        iss_f;
  logic [4:0]  iss_addr;
  // cache return
  logic        m_valid;
  logic        m_ready;
  logic        m_f;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  // hazard check of the current instruction
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic [4:0]  chk_a3;
  logic        chk_f1;
  logic        chk_f2;
  logic        chk_f3;
  logic [2:0]  chk_v;
  logic        stall;
  logic        hold_pipe;
  // register-file write port
  logic        rf_we;
  logic        rf_f;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic        err;

  modport master (
    output p_we, p_f, p_addr, p_data,
    output iss_valid, iss_f, iss_addr,
    output m_valid, m_f, m_addr, m_data,
    output chk_a1, chk_a2, chk_a3, chk_f1, chk_f2, chk_f3, chk_v,
    input  m_ready, stall, hold_pipe,
    input  rf_we, rf_f, rf_addr, rf_wd, err
  );

  modport slave (
    input  p_we, p_f, p_addr, p_data,
    input  iss_valid, iss_f, iss_addr,
    input  m_valid, m_f, m_addr, m_data,
    input  chk_a1, chk_a2, chk_a3, chk_f1, chk_f2, chk_f3, chk_v,
    output m_ready, stall, hold_pipe,
    output rf_we, rf_f, rf_addr, rf_wd, err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
// Merges pipeline writebacks and buffered cache load returns onto the single
// register-file write port, and keeps a 64-entry scoreboard (32 int + 32 FP)
// of outstanding load destinations so the pipeline stalls on hazards.
// Ports:
//   clk  - rising-edge clock
//   RST  - asynchronous active-high reset
//   bus  - rf_wb_if.slave: pipeline writeback (p_*), load issue (iss_*),
//          cache return (m_valid/m_ready/m_f/m_addr/m_data), hazard check
//          (chk_*, stall), forced-drain indication (hold_pipe), register
//          file write port (rf_we/rf_f/rf_addr/rf_wd) and sticky err.
module rf_wb_scheduler #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic    clk,
  input logic    RST,
  rf_wb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);
  localparam logic [AW:0]   ONE_ENTRY   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  typedef struct packed {
    logic        f;
    logic [4:0]  addr;
    logic [31:0] data;
  } ret_t;

  ret_t          fifo_mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   count_s;
  logic [63:0]   pend_r;
  logic [63:0]   pend_nxt_s;
  logic [63:0]   clr_mask_s;
  logic [63:0]   set_mask_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] starve_r;
  logic [CW-1:0] starve_nxt_s;
  logic          err_r;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          blocked_s;
  logic          hold_s;
  logic          p_x0_s;
  logic          pipe_wr_s;
  logic          iss_x0_s;
  logic          head_x0_s;
  logic          head_pend_s;
  ret_t          head_s;

  // FIFO status, write-port arbitration and hazard detection
  always_comb begin
    count_s     = wr_ptr_r - rd_ptr_r;
    empty_s     = (wr_ptr_r == rd_ptr_r);
    // one extra pointer bit distinguishes full from empty
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    head_s      = fifo_mem_r[rd_ptr_r[AW-1:0]];
    hold_s      = (state_r == ST_FORCE);
    p_x0_s      = ~bus.p_f & (bus.p_addr == 5'd0);
    iss_x0_s    = ~bus.iss_f & (bus.iss_addr == 5'd0);
    head_x0_s   = ~head_s.f & (head_s.addr == 5'd0);
    head_pend_s = pend_r[{head_s.f, head_s.addr}];
    pipe_wr_s   = bus.p_we & ~hold_s;
    // a pipeline write to int x0 does not need the port, so the FIFO may use it
    pop_s       = ~empty_s & (hold_s | ~bus.p_we | p_x0_s);
    blocked_s   = ~empty_s & ~pop_s;
    // full blocks pushes even when the head drains this cycle
    push_s      = bus.m_valid & ~full_s;
  end

  assign bus.m_ready   = ~full_s;
  assign bus.hold_pipe = hold_s;
  assign bus.err       = err_r;
  assign bus.stall     = (bus.chk_v[0] & pend_r[{bus.chk_f1, bus.chk_a1}]) |
                         (bus.chk_v[1] & pend_r[{bus.chk_f2, bus.chk_a2}]) |
                         (bus.chk_v[2] & pend_r[{bus.chk_f3, bus.chk_a3}]);

  // register-file write port mux; pop and pipeline write are mutually exclusive
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_f    = 1'b0;
    bus.rf_addr = 5'd0;
    bus.rf_wd   = 32'd0;
    if (pop_s) begin
      bus.rf_we   = ~head_x0_s;
      bus.rf_f    = head_s.f;
      bus.rf_addr = head_s.addr;
      bus.rf_wd   = head_s.data;
    end else if (pipe_wr_s & ~p_x0_s) begin
      bus.rf_we   = 1'b1;
      bus.rf_f    = bus.p_f;
      bus.rf_addr = bus.p_addr;
      bus.rf_wd   = bus.p_data;
    end else begin
      bus.rf_we   = 1'b0;
    end
  end

  // scoreboard next value: clear the drained head, then set the issued load (set wins)
  always_comb begin
    clr_mask_s = pop_s ? (64'd1 << {head_s.f, head_s.addr}) : 64'd0;
    set_mask_s = (bus.iss_valid & ~iss_x0_s) ? (64'd1 << {bus.iss_f, bus.iss_addr}) : 64'd0;
    pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // drain state machine and starvation counter: next-state logic
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_r;
    case (state_r)
      ST_IDLE: begin
        starve_nxt_s = '0;
        if (push_s) begin
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (pop_s) begin
          starve_nxt_s = '0;
          if ((count_s == ONE_ENTRY) && !push_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PEND;
          end
        end else if (blocked_s) begin
          if (starve_r == STARVE_LAST) begin
            starve_nxt_s = '0;
            state_nxt_s  = ST_FORCE;
          end else begin
            starve_nxt_s = starve_r + CW'(1);
            state_nxt_s  = ST_PEND;
          end
        end else begin
          starve_nxt_s = '0;
          state_nxt_s  = ST_PEND;
        end
      end
      ST_FORCE: begin
        // exactly one entry drains in this state
        starve_nxt_s = '0;
        if ((count_s > ONE_ENTRY) || push_s) begin
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        starve_nxt_s = '0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // control state: pointers, scoreboard, FSM, counter and sticky error
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      pend_r   <= 64'd0;
      state_r  <= ST_IDLE;
      starve_r <= '0;
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + ONE_ENTRY) : wr_ptr_r;
      rd_ptr_r <= pop_s ? (rd_ptr_r + ONE_ENTRY) : rd_ptr_r;
      pend_r   <= pend_nxt_s;
      state_r  <= state_nxt_s;
      starve_r <= starve_nxt_s;
      err_r    <= err_r | (pop_s & ~head_pend_s) | (bus.p_we & hold_s);
    end
  end

  // FIFO storage; contents are only read while the pointers say non-empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= '{f: bus.m_f, addr: bus.m_addr, data: bus.m_data};
    end
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-port scheduler and load scoreboard for the integer/FP register file. Merges same-cycle pipeline writebacks with delayed load data returned by the data cache onto the file's single write port (WE3/f/A3/WD3), buffers cache returns in a small FIFO, and tracks destinations of outstanding loads so the pipeline stalls on RAW/WAW hazards. Sits between the core datapath, the data-cache response path, and the register file.

## Interface
Parameters:
- DEPTH, 4, load-return FIFO entries (power of 2, ≥2)
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be blocked before forcing a drain

Ports:
- clk  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- p_we  in  1  pipeline writeback request
- p_f  in  1  1 = FP file, 0 = integer file
- p_addr  in  5  pipeline destination
- p_data  in  32  pipeline write data
- iss_valid  in  1  load issued to cache this cycle
- iss_f  in  1  load destination file
- iss_addr  in  5  load destination
- m_valid  in  1  cache returns load data
- m_ready  out  1  FIFO can accept (= not full)
- m_f, m_addr, m_data  in  1/5/32  returned destination and data
- chk_a1, chk_a2, chk_a3  in  5 each  current instruction sources/destination
- chk_f1, chk_f2, chk_f3  in  1 each  file of each checked register
- chk_v  in  3  valid bit per checked register
- stall  out  1  hazard on a pending register (combinational)
- hold_pipe  out  1  forced-drain cycle; pipeline must not write back
- rf_we, rf_f, rf_addr, rf_wd  out  1/1/5/32  to register file WE3/f/A3/WD3
- err  out  1  sticky: return to a non-pending register, or pipeline write during hold_pipe

## Operation
- Scoreboard: 64 pending bits (32 int, 32 FP). iss_valid sets bit (iss_f,iss_addr); FIFO drain clears bit of head entry. Set and clear of same bit in one cycle: set wins. Integer x0 never set; FP f0 is a normal register.
- stall = OR over i of chk_v[i] & pending(chk_f_i, chk_a_i). Pipeline must hold p_we and iss_valid low while stall=1.
- FIFO push on m_valid & m_ready. m_ready = ~full; no pass-through when full even if popping.
- Write-port mux, priority: hold_pipe drain > pipeline > normal drain.
  - Pipeline write when p_we & ~hold_pipe; integer writes to x0 produce rf_we=0.
  - Drain (pop head, write to RF) when FIFO non-empty and (hold_pipe or ~p_we or pipeline target is int x0).
- State machine (2 bits):
  - IDLE: FIFO empty. → PEND on push.
  - PEND: non-empty; starve counter increments each cycle a drain is blocked by p_we, resets on drain. → FORCE when counter reaches STARVE_MAX-1 and blocked again; → IDLE when last entry drains with no push.
  - FORCE: hold_pipe=1, drain exactly one entry, counter cleared. → PEND if entries remain or push, else IDLE.
- Return to register with pending bit clear: write still performed, err set.
- FIFO pointers log2(DEPTH)+1 bits; full = MSBs differ, lower bits equal; wrap silent.

## Timing
- Reset (RST=1, async): FIFO empty, pending all 0, state IDLE, counter 0, err 0. Outputs: m_ready=1, stall=0, hold_pipe=0, rf_we=0, rf_f=0, rf_addr=0, rf_wd=0.
- Pipeline write: combinational, same cycle to RF.
- Cache return accepted cycle N → earliest RF write cycle N+1; pending bit clear visible (stall drops) cycle N+2.
- iss_valid cycle N → stall for that register from cycle N+1.
- hold_pipe is registered: asserted the cycle after starvation detected, for exactly one cycle.
- Reset mid-operation discards FIFO and scoreboard; in-flight returns after reset raise err.

## Test plan
- Reset, then p_we=1,p_f=0,p_addr=5,p_data=0xDEADBEEF -> same cycle rf_we=1,rf_addr=5,rf_wd=0xDEADBEEF; p_addr=0 -> rf_we=0.
- iss int x7; chk_a1=7,chk_v=001 -> stall=1; m_valid x7 data 0x1234 with p_we=0 -> next cycle rf_we=1,rf_addr=7,rf_wd=0x1234, following cycle stall=0.
- iss FP f3 and int x3; return FP f3 only -> rf_f=1,addr 3 written, int x3 still pending (stall on chk_f1=0,chk_a1=3).
- Fill DEPTH=4 returns with p_we held 1 -> m_ready=0 after 4th push; after 8 blocked cycles hold_pipe=1 for one cycle, one entry drains, m_ready=1.
- Return to non-pending int x9 -> write occurs, err=1 and stays 1 until RST.
